// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter instruction sequencer.
//   - field widths of the PC command interface and of ROM instructions
//   - opcode constants for the control-flow instructions (instr[15:11])
//   - FSM state enum of the sequencer, command enum, strobe-timer phase enum
package pc_seq_pkg;

  localparam int ADDR_W  = 11;
  localparam int REL_W   = 10;
  localparam int INSTR_W = 16;
  localparam int OP_W    = 5;

  localparam logic [OP_W-1:0] OP_JSR  = 5'b11100;
  localparam logic [OP_W-1:0] OP_RET  = 5'b11101;
  localparam logic [OP_W-1:0] OP_JMP  = 5'b11110;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BOOT,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_EXEC,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_HALT,
    ST_ERR
  } state_e;

  // CMD_INC asserts no command line: the PC simply increments on the strobe.
  typedef enum logic [1:0] {
    CMD_INC,
    CMD_PRELOAD,
    CMD_JSR,
    CMD_RET
  } cmd_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_RELEASE
  } phase_e;

endpackage

// File: rtl/pc_seq_strobe.sv
// pc_cmd_strobe: setup/strobe/release timer for one PC command.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_start        : accepted while idle; latches i_cmd/i_addr/i_rel
//   i_cmd          : command to issue (INC drives no command line)
//   i_addr, i_rel  : preload target / JSR offset, passed through unmodified
//   o_busy         : timer is in SETUP, STROBE or RELEASE
//   o_last         : final STROBE cycle (incr drops on the next edge)
//   o_incr         : PC strobe, high for STROBE_CYC cycles
//   o_preload/o_jsr/o_ret/o_addr/o_rel : command levels, held from SETUP
//                    through RELEASE and cleared afterwards
module pc_cmd_strobe
  import pc_seq_pkg::*;
#(
  parameter int STROBE_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  cmd_e              i_cmd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [REL_W-1:0]  i_rel,
  output logic              o_busy,
  output logic              o_last,
  output logic              o_incr,
  output logic              o_preload,
  output logic              o_jsr,
  output logic              o_ret,
  output logic [ADDR_W-1:0] o_addr,
  output logic [REL_W-1:0]  o_rel
);

  localparam logic [2:0] LAST_CNT = 3'(STROBE_CYC - 1);

  phase_e            r_phase;
  logic [2:0]        r_cnt;
  logic              r_incr;
  logic              r_preload;
  logic              r_jsr;
  logic              r_ret;
  logic [ADDR_W-1:0] r_addr;
  logic [REL_W-1:0]  r_rel;

  // Levels are loaded on the edge that enters SETUP, so they are already
  // stable for a full cycle before incr rises, and are only cleared on the
  // edge that leaves RELEASE, a full cycle after incr falls.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase   <= PH_IDLE;
      r_cnt     <= '0;
      r_incr    <= 1'b0;
      r_preload <= 1'b0;
      r_jsr     <= 1'b0;
      r_ret     <= 1'b0;
      r_addr    <= '0;
      r_rel     <= '0;
    end else begin
      case (r_phase)
        PH_IDLE: begin
          if (i_start) begin
            r_phase   <= PH_SETUP;
            r_preload <= (i_cmd == CMD_PRELOAD);
            r_jsr     <= (i_cmd == CMD_JSR);
            r_ret     <= (i_cmd == CMD_RET);
            r_addr    <= i_addr;
            r_rel     <= i_rel;
          end
        end
        PH_SETUP: begin
          r_phase <= PH_STROBE;
          r_incr  <= 1'b1;
          r_cnt   <= '0;
        end
        PH_STROBE: begin
          if (r_cnt == LAST_CNT) begin
            r_phase <= PH_RELEASE;
            r_incr  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        PH_RELEASE: begin
          r_phase   <= PH_IDLE;
          r_preload <= 1'b0;
          r_jsr     <= 1'b0;
          r_ret     <= 1'b0;
          r_addr    <= '0;
          r_rel     <= '0;
        end
        default: r_phase <= PH_IDLE;
      endcase
    end
  end

  assign o_busy    = (r_phase != PH_IDLE);
  assign o_last    = (r_phase == PH_STROBE) && (r_cnt == LAST_CNT);
  assign o_incr    = r_incr;
  assign o_preload = r_preload;
  assign o_jsr     = r_jsr;
  assign o_ret     = r_ret;
  assign o_addr    = r_addr;
  assign o_rel     = r_rel;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetches instructions at pc, decodes control flow and drives
// the PC command interface through a setup/strobe/release sequence.
//   clk, rst_n    : clock, synchronous active-low reset
//   run           : level; a rise while idle boots at RESET_VEC, a fall
//                   returns to idle once the current sequence completes
//   pc, instr     : current PC / ROM data (valid one cycle after rom_en)
//   exec_done     : datapath completion pulse, honoured only in EXEC
//   rom_en        : ROM read enable (high in FETCH)
//   exec_start    : one-cycle pulse on entry to EXEC
//   incr          : PC strobe
//   preload, jsr, ret, addr, relative_addr : PC command levels
//   halted, err   : set in HALT/ERR (err only in ERR), cleared in IDLE
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [10:0] RESET_VEC  = 11'd0,
  parameter int          STROBE_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               exec_done,
  output logic               rom_en,
  output logic               exec_start,
  output logic               incr,
  output logic               preload,
  output logic               jsr,
  output logic               ret,
  output logic [ADDR_W-1:0]  addr,
  output logic [REL_W-1:0]   relative_addr,
  output logic               halted,
  output logic               err
);

  state_e             r_state;
  logic               r_run_d;
  logic               r_in_sub;
  logic [INSTR_W-1:0] r_instr;
  logic               r_rom_en;
  logic               r_exec_start;
  logic               r_halted;
  logic               r_err;

  logic               w_start;
  cmd_e               w_cmd;
  logic [ADDR_W-1:0]  w_addr;
  logic [REL_W-1:0]   w_rel;
  logic [OP_W-1:0]    w_op;
  logic               w_busy;
  logic               w_last;

  assign w_op = r_instr[INSTR_W-1:INSTR_W-OP_W];

  // Command issued to the strobe timer on the edge that enters SETUP.
  always_comb begin
    w_start = 1'b0;
    w_cmd   = CMD_INC;
    w_addr  = '0;
    w_rel   = '0;
    case (r_state)
      ST_BOOT: begin
        w_start = 1'b1;
        w_cmd   = CMD_PRELOAD;
        w_addr  = RESET_VEC;
      end
      ST_DECODE: begin
        case (w_op)
          OP_JMP: begin
            w_start = 1'b1;
            w_cmd   = CMD_PRELOAD;
            w_addr  = r_instr[ADDR_W-1:0];
          end
          OP_JSR: begin
            w_start = !r_in_sub;
            w_cmd   = CMD_JSR;
            w_rel   = r_instr[REL_W-1:0];
          end
          OP_RET: begin
            w_start = r_in_sub;
            w_cmd   = CMD_RET;
          end
          default: ;
        endcase
      end
      ST_EXEC: begin
        w_start = exec_done;
        w_cmd   = CMD_INC;
      end
      default: ;
    endcase
  end

  pc_cmd_strobe #(
    .STROBE_CYC(STROBE_CYC)
  ) u_strobe (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (w_start),
    .i_cmd    (w_cmd),
    .i_addr   (w_addr),
    .i_rel    (w_rel),
    .o_busy   (w_busy),
    .o_last   (w_last),
    .o_incr   (incr),
    .o_preload(preload),
    .o_jsr    (jsr),
    .o_ret    (ret),
    .o_addr   (addr),
    .o_rel    (relative_addr)
  );

  // Main FSM; SETUP/STROBE/RELEASE track the strobe timer's phases so the
  // state always reflects where the PC command sequence is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_run_d      <= 1'b0;
      r_in_sub     <= 1'b0;
      r_instr      <= '0;
      r_rom_en     <= 1'b0;
      r_exec_start <= 1'b0;
      r_halted     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_run_d      <= run;
      r_rom_en     <= 1'b0;
      r_exec_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_halted <= 1'b0;
          r_err    <= 1'b0;
          if (run && !r_run_d) r_state <= ST_BOOT;
        end
        ST_BOOT: begin
          r_in_sub <= 1'b0;
          r_state  <= ST_SETUP;
        end
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_instr <= instr;
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          case (w_op)
            OP_JMP: r_state <= ST_SETUP;
            OP_JSR: begin
              if (r_in_sub) begin
                r_state  <= ST_ERR;
                r_halted <= 1'b1;
                r_err    <= 1'b1;
              end else begin
                r_in_sub <= 1'b1;
                r_state  <= ST_SETUP;
              end
            end
            OP_RET: begin
              if (r_in_sub) begin
                r_in_sub <= 1'b0;
                r_state  <= ST_SETUP;
              end else begin
                r_state  <= ST_ERR;
                r_halted <= 1'b1;
                r_err    <= 1'b1;
              end
            end
            OP_HALT: begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
            default: begin
              r_state      <= ST_EXEC;
              r_exec_start <= 1'b1;
            end
          endcase
        end
        // A falling run is deliberately ignored here: the datapath still owns
        // the instruction, so its completion is awaited before stopping.
        ST_EXEC: if (exec_done) r_state <= ST_SETUP;
        ST_SETUP: r_state <= ST_STROBE;
        ST_STROBE: if (w_last) r_state <= ST_RELEASE;
        ST_RELEASE: begin
          if (run) begin
            r_state  <= ST_FETCH;
            r_rom_en <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HALT, ST_ERR: begin
          if (!run) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rom_en     = r_rom_en;
  assign exec_start = r_exec_start;
  assign halted     = r_halted;
  assign err        = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [10:0] RVEC = 11'h010;
  localparam int          SCYC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [10:0] pc;
  logic [15:0] instr;
  logic        exec_done;
  logic        rom_en, exec_start, incr, preload, jsr, ret, halted, err;
  logic [10:0] addr;
  logic [9:0]  relative_addr;

  pc_sequencer #(.RESET_VEC(RVEC), .STROBE_CYC(SCYC)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pc(pc), .instr(instr),
    .exec_done(exec_done), .rom_en(rom_en), .exec_start(exec_start),
    .incr(incr), .preload(preload), .jsr(jsr), .ret(ret), .addr(addr),
    .relative_addr(relative_addr), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk(input logic p, input logic j, input logic r,
                                     input logic [10:0] a, input logic [9:0] rl);
    return {p, j, r, a, rl};
  endfunction

  logic [23:0] exp_q[$];
  logic [15:0] rom [0:2047];
  logic [10:0] ret_pc;
  int          rom_cnt  = 0;
  int          exec_cnt = 0;
  int          done_cnt = 0;
  logic        pc_incr_d = 1'b0;

  wire [28:0] outs = {rom_en, exec_start, incr, preload, jsr, ret, halted, err, addr, relative_addr};
  wire [23:0] cmd  = {preload, jsr, ret, addr, relative_addr};

  // ROM and PC register model; PC acts on the rising edge of incr.
  always @(negedge clk) begin
    if (rom_en) begin
      instr = rom[pc];
      rom_cnt++;
    end
    if (incr && !pc_incr_d) begin
      if (preload) pc = addr;
      else if (jsr) begin
        ret_pc = pc + 11'd1;
        pc = pc + {1'b0, relative_addr};
      end else if (ret) pc = ret_pc;
      else pc = pc + 11'd1;
    end
    pc_incr_d = incr;
  end

  // Datapath model: completion three cycles after exec_start.
  always @(negedge clk) begin
    exec_done = 1'b0;
    if (exec_start) begin
      exec_cnt++;
      done_cnt = 3;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) exec_done = 1'b1;
    end
  end

  // Command monitor: scoreboard pop on each strobe plus level-stability checks.
  logic        mon_prev_incr = 1'b0;
  logic [23:0] mon_prev_cmd = '0;
  logic [23:0] mon_held = '0;
  int          mon_len = 0;
  logic [23:0] mon_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_incr = 1'b0;
      mon_len = 0;
    end else begin
      if (incr && !mon_prev_incr) begin
        if (exp_q.size() == 0) check("exp_q_nonempty", exp_q.size(), 1);
        else begin
          mon_exp = exp_q.pop_front();
          check("strobe_cmd", {8'd0, cmd}, {8'd0, mon_exp});
        end
        check("setup_hold", {8'd0, cmd}, {8'd0, mon_prev_cmd});
        mon_held = cmd;
        mon_len = 1;
      end else if (incr) begin
        check("strobe_hold", {8'd0, cmd}, {8'd0, mon_held});
        mon_len++;
      end else if (mon_prev_incr) begin
        check("release_hold", {8'd0, cmd}, {8'd0, mon_held});
        check("strobe_len", mon_len, SCYC);
      end
      mon_prev_incr = incr;
      mon_prev_cmd = cmd;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
  endtask

  task automatic wait_halted(input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic stop_run();
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_halted_clr", halted, 0);
    check("idle_err_clr", err, 0);
  endtask

  int cyc;
  int rc0;

  initial begin
    rst_n = 1'b0; run = 1'b0; exec_done = 1'b0; instr = '0; pc = '0; ret_pc = '0;
    clear_rom();
    repeat (3) @(negedge clk);
    check("reset_outs", outs, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", outs, 0);

    // Program A: ordinary, JMP, JSR, RET, HALT
    rom[11'h010] = 16'h1234;
    rom[11'h011] = 16'hF055;
    rom[11'h055] = 16'hE003;
    rom[11'h058] = 16'hE800;
    rom[11'h056] = 16'hF800;
    exp_q.push_back(mk(1, 0, 0, 11'h010, 10'h0));
    exp_q.push_back(mk(0, 0, 0, 11'h000, 10'h0));
    exp_q.push_back(mk(1, 0, 0, 11'h055, 10'h0));
    exp_q.push_back(mk(0, 1, 0, 11'h000, 10'h003));
    exp_q.push_back(mk(0, 0, 1, 11'h000, 10'h0));
    exec_cnt = 0;
    run = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 30) begin
      @(posedge clk);
      cyc++;
      #1;
      if (rom_en) break;
    end
    check("boot_latency", cyc, 3 + SCYC);
    check("first_fetch_pc", pc, RVEC);
    wait_halted(400);
    check("a_err", err, 0);
    check("a_exec_starts", exec_cnt, 1);
    check("a_queue_left", exp_q.size(), 0);
    check("a_final_pc", pc, 11'h056);
    rc0 = rom_cnt;
    repeat (20) @(negedge clk);
    check("a_no_fetch_halt", rom_cnt, rc0);
    stop_run();

    // Program B: nested JSR -> ERR
    clear_rom();
    rom[11'h010] = 16'hE001;
    rom[11'h011] = 16'hE002;
    exp_q.push_back(mk(1, 0, 0, 11'h010, 10'h0));
    exp_q.push_back(mk(0, 1, 0, 11'h000, 10'h001));
    run = 1'b1;
    wait_halted(200);
    check("b_err", err, 1);
    check("b_queue_left", exp_q.size(), 0);
    stop_run();

    // Program C: RET right after boot -> ERR
    clear_rom();
    rom[11'h010] = 16'hE800;
    exp_q.push_back(mk(1, 0, 0, 11'h010, 10'h0));
    run = 1'b1;
    wait_halted(200);
    check("c_err", err, 1);
    check("c_queue_left", exp_q.size(), 0);
    stop_run();

    // Program D: reset in the middle of the boot strobe, then HALT
    clear_rom();
    rom[11'h010] = 16'hF800;
    exp_q.push_back(mk(1, 0, 0, 11'h010, 10'h0));
    run = 1'b1;
    cyc = 0;
    while (!incr && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("d_strobe_seen", incr, 1);
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    @(posedge clk);
    #1;
    check("d_reset_outs", outs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rc0 = rom_cnt;
    repeat (6) @(negedge clk);
    check("d_idle_after_rst", outs, 0);
    check("d_no_fetch_idle", rom_cnt, rc0);
    exp_q.push_back(mk(1, 0, 0, 11'h010, 10'h0));
    run = 1'b1;
    wait_halted(200);
    check("d_err", err, 0);
    check("d_queue_left", exp_q.size(), 0);
    rc0 = rom_cnt;
    repeat (20) @(negedge clk);
    check("d_no_fetch_halt", rom_cnt, rc0);
    stop_run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
